fir_output_serializer: RTL and testbench

Output-side companion to the L=3 parallel FIR filters (`fir_parallel_L3`, `fir_parallel_L3_pipeline`). It accepts one block of L parallel filter outputs per valid cycle, buffers whole blocks, and emits them as a single-lane sample stream with a valid/ready handshake, oldest lane first. It sits between the parallel filter's `y1..yL` outputs and any serial consumer, such as a DAC interface or the result checker.

---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_output_serializer_if.sv | 36 +++
 rtl/fir_block_fifo.sv | 76 +++++++
 rtl/fir_output_serializer.sv | 89 ++++++++
 tb/tb_fir_output_serializer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types for the L=3 parallel FIR family.
// Contents: default sample width and lane count, sample/block types.
package fir_pkg;

    localparam int unsigned FIR_WIDTH = 32;
    localparam int unsigned FIR_L3    = 3;

    typedef logic signed [FIR_WIDTH-1:0] sample_t;
    typedef sample_t [FIR_L3-1:0]         block_t;

endpackage : fir_pkg

// File: rtl/fir_output_serializer_if.sv
// Handshake bundle between a parallel FIR block producer and a serial consumer.
// Producer side : in_valid, in_y (lane 0 oldest), in_ready.
// Consumer side : out_valid, out_data, out_lane, out_ready.
// Status        : overflow, and drop_count when FIR_SER_DROPCNT_EN is defined.
// slave = serializer side, master = environment side.
interface fir_output_serializer_if
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH,
    parameter int unsigned L     = FIR_L3
);
    localparam int unsigned LW = $clog2(L);

    logic                        in_valid;
    logic [L-1:0][WIDTH-1:0]     in_y;
    logic                        in_ready;
    logic                        out_valid;
    logic signed [WIDTH-1:0]     out_data;
    logic [LW-1:0]               out_lane;
    logic                        out_ready;
    logic                        overflow;
`ifdef FIR_SER_DROPCNT_EN
    logic [15:0]                 drop_count;

    modport slave  (input  in_valid, in_y, out_ready,
                    output in_ready, out_valid, out_data, out_lane, overflow, drop_count);
    modport master (output in_valid, in_y, out_ready,
                    input  in_ready, out_valid, out_data, out_lane, overflow, drop_count);
`else
    modport slave  (input  in_valid, in_y, out_ready,
                    output in_ready, out_valid, out_data, out_lane, overflow);
    modport master (output in_valid, in_y, out_ready,
                    input  in_ready, out_valid, out_data, out_lane, overflow);
`endif

endinterface : fir_output_serializer_if

// File: rtl/fir_block_fifo.sv
// Block FIFO: DEPTH entries of L x WIDTH samples, with a separate occupancy count.
// Ports: clk, rst (sync, active-low), i_push/i_data write side, i_pop read side,
//        o_full/o_empty status (registered), o_head = oldest stored block.
// Push while full and pop while empty are ignored. Storage is zeroed on reset.
module fir_block_fifo
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH,
    parameter int unsigned L     = FIR_L3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [L-1:0][WIDTH-1:0] i_data,
    input  logic                    i_pop,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [L-1:0][WIDTH-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [L-1:0][WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_full;
    logic                    r_empty;
    logic [CW-1:0]           w_count_nxt;
    logic                    w_push;
    logic                    w_pop;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop  && !r_empty;

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage, wrapping pointers, and status flags registered from the next count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == CW'(0));
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_head  = r_mem[r_rd_ptr];

endmodule : fir_block_fifo

// File: rtl/fir_output_serializer.sv
// Serializes blocks of L parallel FIR outputs into a single-lane valid/ready
// stream, oldest lane first. Whole blocks are buffered in fir_block_fifo.
// Ports: clk, rst (sync, active-low), bus (fir_output_serializer_if.slave).
// Blocks arriving while the FIFO is full are dropped and set the sticky
// overflow flag. Optional macro FIR_SER_DROPCNT_EN adds a saturating 16-bit
// drop counter on bus.drop_count.
module fir_output_serializer
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH,
    parameter int unsigned L     = FIR_L3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    fir_output_serializer_if.slave         bus
);
    localparam int unsigned LW = $clog2(L);

    logic                    w_full;
    logic                    w_empty;
    logic [L-1:0][WIDTH-1:0] w_head;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_beat;
    logic                    w_last_lane;
    logic                    w_pop;
    logic [LW-1:0]           r_lane;
    logic                    r_overflow;

    // Acceptance depends only on FIFO occupancy, never on out_ready.
    assign w_push      = bus.in_valid && !w_full;
    assign w_drop      = bus.in_valid &&  w_full;
    assign w_beat      = !w_empty && bus.out_ready;
    assign w_last_lane = (r_lane == LW'(L - 1));
    assign w_pop       = w_beat && w_last_lane;

    fir_block_fifo #(
        .WIDTH (WIDTH),
        .L     (L),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (bus.in_y),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Lane counter walks the head block; the final beat retires it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lane     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_beat) begin
                r_lane <= w_last_lane ? '0 : r_lane + LW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef FIR_SER_DROPCNT_EN
    logic [15:0] r_drop_count;

    // Saturating count of dropped blocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'(1);
        end
    end

    assign bus.drop_count = r_drop_count;
`endif

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head[r_lane];
    assign bus.out_lane  = r_lane;
    assign bus.overflow  = r_overflow;

endmodule : fir_output_serializer

// File: tb/tb_fir_output_serializer.sv
// Self-checking bench for fir_output_serializer: directed tables, multi-cycle
// corner sequences, and randomized traffic against a sample-queue reference.
module tb_fir_output_serializer;
    import fir_pkg::*;

    localparam int unsigned WIDTH = FIR_WIDTH;
    localparam int unsigned L     = FIR_L3;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_output_serializer_if #(.WIDTH(WIDTH), .L(L)) bus ();

    fir_output_serializer #(.WIDTH(WIDTH), .L(L), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: flat queue of pending samples in emission order.
    int q[$];
    bit m_ovf   = 1'b0;
    int m_drops = 0;
    int n_beats = 0;

    typedef struct {
        logic iv;
        int   y0, y1, y2;
        logic ordy;
        logic e_valid;
        int   e_data;
        int   e_lane;
        logic e_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_blocks();
        return (q.size() + int'(L) - 1) / int'(L);
    endfunction

    task automatic check_outputs();
        chk("out_valid", bus.out_valid, (q.size() != 0));
        chk("in_ready",  bus.in_ready,  (m_blocks() != int'(DEPTH)));
        if (q.size() != 0) begin
            chk("out_data", bus.out_data, q[0]);
            chk("out_lane", bus.out_lane, (int'(L) - (q.size() % int'(L))) % int'(L));
        end
        chk("overflow", bus.overflow, m_ovf);
`ifdef FIR_SER_DROPCNT_EN
        chk("drop_count", bus.drop_count, m_drops);
`endif
    endtask

    function automatic void model_step(logic iv, block_t y, logic ordy);
        bit full;
        full = (m_blocks() == int'(DEPTH));
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (iv) begin
            if (!full) begin
                for (int k = 0; k < int'(L); k++) q.push_back(int'(y[k]));
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
    endfunction

    task automatic drive(input logic iv, input int a, input int b, input int c,
                         input logic ordy);
        bus.in_valid  = iv;
        bus.in_y[0]   = a;
        bus.in_y[1]   = b;
        bus.in_y[2]   = c;
        bus.out_ready = ordy;
    endtask

    // One clock: check settled outputs, advance the model, take the edge.
    task automatic cycle();
        block_t y;
        check_outputs();
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) n_beats++;
        y = bus.in_y;
        model_step(bus.in_valid, y, bus.out_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        rst     = 1'b1;
    endtask

    function automatic void add(logic iv, int y0, int y1, int y2, logic ordy,
                                logic ev, int ed, int el, logic er);
        vec_t v;
        v.iv = iv; v.y0 = y0; v.y1 = y1; v.y2 = y2; v.ordy = ordy;
        v.e_valid = ev; v.e_data = ed; v.e_lane = el; v.e_rdy = er;
        tbl.push_back(v);
    endfunction

    initial begin
        int b0;
        drive(1'b0, 0, 0, 0, 1'b0);

        // Reset held two cycles.
        do_reset(2);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_lane",  bus.out_lane,  0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_overflow",  bus.overflow,  0);
`ifdef FIR_SER_DROPCNT_EN
        chk("rst_drop_count", bus.drop_count, 0);
`endif

        // Single block, then backpressured block; expectations after each edge.
        add(1, 10, 20, 30, 1,  1, 10, 0, 1);
        add(0,  0,  0,  0, 1,  1, 20, 1, 1);
        add(0,  0,  0,  0, 1,  1, 30, 2, 1);
        add(0,  0,  0,  0, 1,  0,  0, 0, 1);
        add(1, -5,  7,  9, 0,  1, -5, 0, 1);
        for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 1, -5, 0, 1);
        add(0,  0,  0,  0, 1,  1,  7, 1, 1);
        add(0,  0,  0,  0, 1,  1,  9, 2, 1);
        add(0,  0,  0,  0, 1,  0,  0, 0, 1);
        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].y0, tbl[i].y1, tbl[i].y2, tbl[i].ordy);
            cycle();
            chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_rdy);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_lane", i), bus.out_lane, tbl[i].e_lane);
            end
        end

        // Rated stream: one block every L cycles never fills the FIFO.
        b0 = n_beats;
        for (int b = 0; b < 30; b++) begin
            for (int c = 0; c < int'(L); c++) begin
                drive(c == 0, 100 + 3*b, 101 + 3*b, 102 + 3*b, 1'b1);
                cycle();
            end
        end
        drive(1'b0, 0, 0, 0, 1'b1);
        repeat (4) cycle();
        chk("rated_beats", n_beats - b0, 90);
        chk("rated_overflow", bus.overflow, 0);

        // Overflow: five consecutive pushes into a stalled four-deep FIFO.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1000 + 10*i, 1001 + 10*i, 1002 + 10*i, 1'b0);
            cycle();
            if (i == 3) begin
                chk("ovf_in_ready_full", bus.in_ready, 0);
                chk("ovf_flag_before_drop", bus.overflow, 0);
            end
        end
        chk("ovf_flag", bus.overflow, 1);
`ifdef FIR_SER_DROPCNT_EN
        chk("ovf_drop_count", bus.drop_count, 1);
`endif
        b0 = n_beats;
        drive(1'b0, 0, 0, 0, 1'b1);
        repeat (14) cycle();
        chk("ovf_drain_beats", n_beats - b0, 12);
        chk("ovf_drain_empty", bus.out_valid, 0);
        chk("ovf_sticky", bus.overflow, 1);

        // Reset mid-block with two blocks queued.
        do_reset(1);
        drive(1'b1, 51, 52, 53, 1'b0); cycle();
        drive(1'b1, 61, 62, 63, 1'b0); cycle();
        drive(1'b0, 0, 0, 0, 1'b1);    cycle();
        chk("midrst_lane_before", bus.out_lane, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        rst     = 1'b1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready",  bus.in_ready,  1);
        chk("midrst_out_lane",  bus.out_lane,  0);
        chk("midrst_out_data",  bus.out_data,  0);
        b0 = n_beats;
        repeat (6) cycle();
        chk("midrst_no_output", n_beats - b0, 0);

        // Randomized traffic against the reference queue.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            int pr;
            pr = (i < 1500) ? 35 : 85;
            if ($urandom_range(0, 699) == 0) do_reset(1);
            drive($urandom_range(0, 99) < 40,
                  int'($urandom), int'($urandom), int'($urandom),
                  $urandom_range(0, 99) < pr);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fir_output_serializer
